// File: rtl/global_in_fea_wr_if.sv
`default_nettype none
// ============================================================================
// Module   : global_in_fea_wr_if
// Brief    : Sample stream in / feature BRAM write port out for global_in_fea_wr.
// Revision : 1.0
// ============================================================================
interface global_in_fea_wr_if #(
    parameter int DW    = 16,
    parameter int VEC_N = 25,
    parameter int DEPTH = 450,
    parameter int AW    = $clog2(DEPTH)
);
    logic                  start;
    logic                  din_v;
    logic [DW-1:0]         din;
    logic                  din_rdy;
    logic                  wea;
    logic [AW-1:0]         waddr;
    logic [DW*VEC_N-1:0]   wdata;
    logic                  busy;
    logic                  done;

    modport master (
        output start, din_v, din,
        input  din_rdy, wea, waddr, wdata, busy, done
    );

    modport slave (
        input  start, din_v, din,
        output din_rdy, wea, waddr, wdata, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/global_in_fea_wr.sv
`default_nettype none
// ============================================================================
// Module   : global_in_fea_wr
// Brief    : Packs 25 x 16-bit samples per word and writes 450 words to BRAM.
// Revision : 1.0
// ============================================================================
module global_in_fea_wr #(
    parameter int DW    = 16,
    parameter int VEC_N = 25,
    parameter int DEPTH = 450
) (
    input  wire logic          clk,
    input  wire logic          rst,
    global_in_fea_wr_if.slave  bus
);
    localparam int WW = DW * VEC_N;
    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(VEC_N);
    localparam logic [KW-1:0] C_LAST_K = KW'(VEC_N - 1);
    localparam logic [AW-1:0] C_LAST_W = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [AW-1:0]   word_q;
    logic [WW-1:0]   pack_q;
    logic [WW-1:0]   pack_d;
    logic            din_rdy_q;
    logic            wea_q;
    logic [AW-1:0]   waddr_q;
    logic [WW-1:0]   wdata_q;
    logic            busy_q;
    logic            done_q;

    // Pack register with the incoming sample merged in, so the 25th sample
    // reaches wdata on the same edge that raises wea.
    always_comb begin
        pack_d = pack_q;
        for (int j = 0; j < VEC_N; j++) begin
            if (k_q == KW'(j)) begin
                pack_d[j*DW +: DW] = bus.din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            word_q    <= '0;
            pack_q    <= '0;
            din_rdy_q <= 1'b0;
            wea_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_PACK;
                        din_rdy_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_PACK: begin
                    if (bus.din_v) begin
                        pack_q <= pack_d;
                        if (k_q == C_LAST_K) begin
                            k_q       <= '0;
                            state_q   <= S_WRITE;
                            din_rdy_q <= 1'b0;
                            wea_q     <= 1'b1;
                            waddr_q   <= word_q;
                            wdata_q   <= pack_d;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    wea_q <= 1'b0;
                    if (word_q == C_LAST_W) begin
                        word_q  <= '0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        word_q    <= word_q + AW'(1);
                        state_q   <= S_PACK;
                        din_rdy_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.din_rdy = din_rdy_q;
    assign bus.wea     = wea_q;
    assign bus.waddr   = waddr_q;
    assign bus.wdata   = wdata_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_global_in_fea_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_global_in_fea_wr
// Brief    : Directed vector table plus full-load sequences for global_in_fea_wr.
// Revision : 1.0
// ============================================================================
module tb_global_in_fea_wr;
    localparam int C_SAMPLES = 11250;

    logic clk;
    logic rst;

    global_in_fea_wr_if bus ();

    global_in_fea_wr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        s;
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic        wea;
        logic        busy;
        logic        done;
        logic [8:0]  wa;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [8:0]  wa_q[$];
    logic [399:0] wd_q[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.wea === 1'b1) begin
            wa_q.push_back(bus.waddr);
            wd_q.push_back(bus.wdata);
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic vec_t mk(input logic r, input logic s, input logic v,
                                input logic [15:0] d, input logic rdy,
                                input logic wea, input logic busy, input logic done,
                                input logic [8:0] wa, input logic [15:0] lo,
                                input logic [15:0] hi);
        vec_t t;
        t.r = r; t.s = s; t.v = v; t.d = d;
        t.rdy = rdy; t.wea = wea; t.busy = busy; t.done = done;
        t.wa = wa; t.lo = lo; t.hi = hi;
        return t;
    endfunction

    function automatic logic [399:0] exp_word(input int base);
        logic [399:0] w;
        w = '0;
        for (int k = 0; k < 25; k++) w[k*16 +: 16] = 16'(base + k);
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        bus.din_v = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_load(input bit gaps, input int restart_word, input int abort_word,
                            output int last, output bit aborted);
        int s = 0;
        int budget = 0;
        bit pulsed = 1'b0;
        logic dv;
        last = 0;
        aborted = 1'b0;
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        pulse_start();
        while (s < C_SAMPLES && budget < 40000 && !aborted) begin
            bus.start = 1'b0;
            if (restart_word >= 0 && !pulsed && wa_q.size() == restart_word) begin
                bus.start = 1'b1;
                pulsed = 1'b1;
            end
            if (abort_word >= 0 && wa_q.size() == abort_word && (s % 25) == 10) begin
                aborted = 1'b1;
                rst = 1'b1;
                bus.din_v = 1'b1;
            end else begin
                dv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.din_v = dv;
                bus.din = 16'(s);
                if (dv && bus.din_rdy === 1'b1) begin
                    last = cyc;
                    s++;
                end
            end
            @(negedge clk);
            budget++;
        end
        bus.start = 1'b0;
        bus.din_v = 1'b0;
        if (budget >= 40000) chk("load_timeout", 64'(s), 64'(C_SAMPLES));
    endtask

    task automatic post_checks(input string tag, input int last);
        int guard = 0;
        int bad = -1;
        while (done_cnt == 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'd450);
        for (int i = 0; i < wa_q.size(); i++) begin
            if (bad < 0 && (wa_q[i] !== 9'(i) || wd_q[i] !== exp_word(i * 25))) bad = i;
        end
        chk({tag, "_order_first_bad_plus1"}, 64'(bad + 1), 64'd0);
        chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_latency"}, 64'(done_cyc - last), 64'd2);
        chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int last;
        bit aborted;
        int guard;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.din_v = 1'b0;
        bus.din = '0;

        // Cycle-accurate vectors: inputs held for one cycle, outputs after the edge.
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 9'd0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 0, 1, 16'hBEEF, 0, 0, 0, 0, 9'd0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 16'hBEEF, 1, 0, 1, 0, 9'd0, 16'h0000, 16'h0000));
        for (int i = 0; i < 24; i++)
            tbl.push_back(mk(0, 0, 1, 16'(i), 1, 0, 1, 0, 9'd0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 16'h0018, 0, 1, 1, 0, 9'd0, 16'h0000, 16'h0018));
        tbl.push_back(mk(0, 0, 1, 16'h1234, 1, 0, 1, 0, 9'd0, 16'h0000, 16'h0018));
        tbl.push_back(mk(0, 0, 1, 16'h1234, 1, 0, 1, 0, 9'd0, 16'h0000, 16'h0018));
        for (int i = 1; i < 24; i++)
            tbl.push_back(mk(0, 0, 1, 16'(16'h0100 + i), 1, 0, 1, 0, 9'd0, 16'h0000, 16'h0018));
        tbl.push_back(mk(0, 0, 1, 16'h0118, 0, 1, 1, 0, 9'd1, 16'h1234, 16'h0118));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 1, 0, 9'd1, 16'h1234, 16'h0118));
        tbl.push_back(mk(1, 0, 1, 16'h0000, 0, 0, 0, 0, 9'd0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 9'd0, 16'h0000, 16'h0000));

        repeat (2) @(negedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r;
            bus.start = tbl[i].s;
            bus.din_v = tbl[i].v;
            bus.din = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                64'({bus.din_rdy, bus.wea, bus.busy, bus.done, bus.waddr,
                     bus.wdata[15:0], bus.wdata[399:384]}),
                64'({tbl[i].rdy, tbl[i].wea, tbl[i].busy, tbl[i].done, tbl[i].wa,
                     tbl[i].lo, tbl[i].hi}));
        end
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        bus.din_v = 1'b0;

        run_load(1'b0, -1, -1, last, aborted);
        post_checks("cont", last);

        run_load(1'b1, -1, -1, last, aborted);
        post_checks("gaps", last);

        run_load(1'b0, 10, -1, last, aborted);
        post_checks("restart", last);

        // Reset in the middle of word 200: no further writes, no done, then clean restart.
        run_load(1'b0, -1, 200, last, aborted);
        chk("abort_taken", 64'(aborted), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.din_v = 1'b1;
        repeat (60) @(negedge clk);
        bus.din_v = 1'b0;
        chk("abort_no_write", 64'(wa_q.size()), 64'd200);
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        pulse_start();
        for (int k = 0; k < 25; k++) begin
            bus.din_v = 1'b1;
            bus.din = 16'(16'hA000 + k);
            @(negedge clk);
        end
        bus.din_v = 1'b0;
        guard = 0;
        while (wa_q.size() < 201 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("restart_nwrites", 64'(wa_q.size()), 64'd201);
        if (wa_q.size() >= 201) begin
            chk("restart_addr", 64'(wa_q[200]), 64'd0);
            chk("restart_lo", 64'(wd_q[200][63:0]), 64'(exp_word(32'hA000) >> 0));
            chk("restart_word", 64'(wd_q[200] == exp_word(32'hA000)), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/global_in_fea_wr.md
GLOBAL_IN_FEA_WR -- requirements
Module: GLOBAL_IN_FEA_WR

Interface
REQ-001 Parameter DW, 16, bit width of one feature sample.
REQ-002 Parameter VEC_N, 25, samples packed per BRAM word; word width = DW*VEC_N = 400.
REQ-003 Parameter DEPTH, 450, BRAM words per full input feature (150*3).
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins loading one full input feature.
REQ-007 din_v  input  1  sample valid.
REQ-008 din  input  16  feature sample.
REQ-009 din_rdy  output  1  block accepts a sample this cycle; a transfer occurs when din_v && din_rdy.
REQ-010 wea  output  1  BRAM write enable, port-A write side of the feature BRAM.
REQ-011 waddr  output  9  BRAM write address.
REQ-012 wdata  output  400  BRAM write data.
REQ-013 busy  output  1  high from the cycle after an accepted start until the cycle done pulses, inclusive.
REQ-014 done  output  1  one-cycle pulse after the last word (address DEPTH-1) is written.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, PACK, WRITE and DONE.
REQ-016 IDLE -> PACK on start; in IDLE the word address counter and sample counter SHALL be 0.
REQ-017 PACK: din_rdy=1; each transfer SHALL place din into bits [16k+15:16k] of the pack register, where k = sample counter (0..24), and increment k.
REQ-018 PACK -> WRITE on the transfer with k=24; k SHALL wrap to 0.
REQ-019 WRITE lasts exactly one cycle: wea=1, waddr = word counter, wdata = pack register; din_rdy=0.
REQ-020 WRITE -> PACK with the word counter incremented if the word counter < DEPTH-1; otherwise WRITE -> DONE with the word counter cleared to 0.
REQ-021 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-022 Latency: if the 25th sample of a word transfers at cycle N, wea SHALL be high at cycle N+1 and PACK SHALL accept again at N+2.
REQ-023 start SHALL be ignored in PACK, WRITE and DONE; start and din_v in the same IDLE cycle SHALL NOT transfer the sample (din_rdy=0 in IDLE).
REQ-024 din_v while din_rdy=0 SHALL NOT be captured; the upstream source holds the sample until a transfer occurs.
REQ-025 wea SHALL be 0 in all states except WRITE; waddr and wdata SHALL hold their last values when wea=0.
REQ-026 A full load SHALL write addresses 0..449 in ascending order, each exactly once, consuming exactly 11250 samples.
REQ-027 Gaps in din_v SHALL stall packing without losing or duplicating samples.
REQ-028 The pack register SHALL NOT be cleared between words; every bit is overwritten before each write.

Reset
REQ-029 While rst=1 the FSM SHALL enter IDLE; din_rdy, wea, busy and done SHALL be 0; waddr, wdata, the pack register and both counters SHALL be 0.
REQ-030 rst asserted mid-load SHALL abort the load with no further writes and no done pulse; BRAM words already written SHALL remain untouched; the next start SHALL restart at address 0, sample 0.

Verification
REQ-031 Reset then start, then 25 samples 0x0000..0x0018 with din_v continuous -> one write at waddr=0 whose wdata[15:0]=0x0000 and wdata[399:384]=0x0018, wea high on the cycle after the 25th transfer.
REQ-032 Full load of 11250 incrementing samples -> 450 writes at addresses 0..449 in order, one done pulse 2 cycles after the 25th sample of word 449, busy low afterwards.
REQ-033 din_v toggled pseudo-randomly 50% during a load -> written data identical to the continuous case, no dropped or duplicated samples.
REQ-034 start pulsed again at word 10 of a load -> ignored; addresses continue 10, 11, ... and exactly one done pulse.
REQ-035 rst pulsed during word 200 -> wea stays 0 and no done pulse; a new start then writes address 0 first.
REQ-036 din_v held high through every WRITE cycle -> din_rdy=0 in WRITE and the held sample is captured as k=0 of the next word.
